// File: rtl/mpq_host.sv
// mpq_host: script-driven host for a priority-queue engine. Reads a script
// from byte memory, resets and loads the queue, issues commands, captures
// result writes into a 256-byte buffer and flags completion.
// Ports: clk, rst (async, active high), start; mem_rd/mem_addr/mem_q script
// memory; mpq_rst, data_valid/data load stream; cmd_valid/cmd/index/value
// command port; busy, RAM_valid/RAM_A/RAM_D, done from the queue;
// rd_addr/rd_data result readback; finish, res_cnt, pass status.
// Optional macro MPQ_HOST_CHK_SUM_EN: read an expected checksum byte after
// the terminal record and set pass when it equals the sum of captured data.
module mpq_host (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       mem_rd,
    output logic [9:0] mem_addr,
    input  logic [7:0] mem_q,
    output logic       mpq_rst,
    output logic       data_valid,
    output logic [7:0] data,
    output logic       cmd_valid,
    output logic [2:0] cmd,
    output logic [7:0] index,
    output logic [7:0] value,
    input  logic       busy,
    input  logic       RAM_valid,
    input  logic [7:0] RAM_A,
    input  logic [7:0] RAM_D,
    input  logic       done,
    input  logic [7:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       finish,
    output logic [8:0] res_cnt,
    output logic       pass
);

    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_PRE   = 4'd1;
    localparam logic [3:0] S_LOAD  = 4'd2;
    localparam logic [3:0] S_WLOAD = 4'd3;
    localparam logic [3:0] S_FETCH = 4'd4;
    localparam logic [3:0] S_ISSUE = 4'd5;
    localparam logic [3:0] S_WBUSY = 4'd6;
    localparam logic [3:0] S_CAPT  = 4'd7;
    localparam logic [3:0] S_FIN   = 4'd8;

    logic [3:0] r_state;
    logic [9:0] r_addr;
    logic [7:0] r_n;
    logic [7:0] r_cnt;
    logic [1:0] r_fc;
    logic       r_term;
    logic       r_skip;
    logic       r_finish;
    logic [2:0] r_cmd;
    logic [7:0] r_index;
    logic [7:0] r_value;
    logic [8:0] r_res_cnt;
    logic [7:0] r_buf [256];

    logic w_idle;
    logic w_rd;
    logic w_wr;

`ifdef MPQ_HOST_CHK_SUM_EN
    logic       r_cs_rd;
    logic       r_cs_got;
    logic [7:0] r_sum;
    logic [7:0] r_exp;
    logic       r_pass;
`endif

    assign w_idle = (r_state == S_IDLE) || (r_state == S_FIN);
    assign w_wr   = (r_state == S_CAPT) && RAM_valid;

    // Read strobe is combinational so byte 0 is fetched in the start cycle
    // and byte 1 during PRE, letting the load stream begin right after PRE.
    always_comb begin
        w_rd = 1'b0;
        case (r_state)
            S_IDLE, S_FIN: w_rd = start;
            S_PRE:         w_rd = 1'b1;
            S_LOAD:        w_rd = (r_cnt < r_n);
            S_FETCH:       w_rd = (r_fc != 2'd3);
`ifdef MPQ_HOST_CHK_SUM_EN
            S_CAPT:        w_rd = !r_cs_rd;
`endif
            default:       w_rd = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_addr    <= '0;
            r_n       <= '0;
            r_cnt     <= '0;
            r_fc      <= '0;
            r_term    <= 1'b0;
            r_skip    <= 1'b0;
            r_finish  <= 1'b0;
            r_cmd     <= '0;
            r_index   <= '0;
            r_value   <= '0;
            r_res_cnt <= '0;
        end else begin
            if (w_idle) begin
                if (start) r_addr <= 10'd1;
            end else if (w_rd) begin
                r_addr <= r_addr + 10'd1;
            end
            if (w_wr && (r_res_cnt != 9'd256))
                r_res_cnt <= r_res_cnt + 9'd1;
            case (r_state)
                S_IDLE, S_FIN: begin
                    if (start) begin
                        r_state   <= S_PRE;
                        r_res_cnt <= '0;
                        r_finish  <= 1'b0;
                    end
                end
                S_PRE: begin
                    r_n     <= mem_q;
                    r_cnt   <= 8'd1;
                    r_state <= S_LOAD;
                end
                S_LOAD: begin
                    if (r_cnt < r_n) r_cnt <= r_cnt + 8'd1;
                    else             r_state <= S_WLOAD;
                end
                S_WLOAD: begin
                    if (!busy) begin
                        r_fc    <= '0;
                        r_state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    r_fc <= r_fc + 2'd1;
                    case (r_fc)
                        2'd1: begin
                            r_cmd  <= mem_q[2:0];
                            r_term <= (mem_q >= 8'd4);
                        end
                        2'd2: r_index <= mem_q;
                        2'd3: begin
                            r_value <= mem_q;
                            r_state <= S_ISSUE;
                        end
                        default: ;
                    endcase
                end
                S_ISSUE: begin
                    if (!busy) begin
                        r_skip  <= 1'b1;
                        r_state <= r_term ? S_CAPT : S_WBUSY;
                    end
                end
                S_WBUSY: begin
                    // Queue raises busy one cycle late; skip that cycle.
                    if (r_skip) begin
                        r_skip <= 1'b0;
                    end else if (!busy) begin
                        r_fc    <= '0;
                        r_state <= S_FETCH;
                    end
                end
                S_CAPT: begin
                    if (RAM_valid && done) begin
                        r_finish <= 1'b1;
                        r_state  <= S_FIN;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_buf[RAM_A] <= RAM_D;
    end

`ifdef MPQ_HOST_CHK_SUM_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cs_rd  <= 1'b0;
            r_cs_got <= 1'b0;
            r_sum    <= '0;
            r_exp    <= '0;
            r_pass   <= 1'b0;
        end else if (w_idle && start) begin
            r_cs_rd  <= 1'b0;
            r_cs_got <= 1'b0;
            r_sum    <= '0;
            r_pass   <= 1'b0;
        end else begin
            if ((r_state == S_CAPT) && !r_cs_rd) r_cs_rd <= 1'b1;
            if (r_cs_rd && !r_cs_got) begin
                r_exp    <= mem_q;
                r_cs_got <= 1'b1;
            end
            if (w_wr) r_sum <= r_sum + RAM_D;
            if (r_state == S_FIN) r_pass <= r_cs_got && (r_sum == r_exp);
        end
    end
    assign pass = r_pass;
`else
    assign pass = 1'b0;
`endif

    assign mem_rd     = w_rd;
    assign mem_addr   = w_idle ? 10'd0 : r_addr;
    assign mpq_rst    = (r_state == S_PRE);
    assign data_valid = (r_state == S_LOAD);
    assign data       = data_valid ? mem_q : 8'd0;
    assign cmd_valid  = (r_state == S_ISSUE) && !busy;
    assign cmd        = r_cmd;
    assign index      = r_index;
    assign value      = r_value;
    assign finish     = r_finish;
    assign res_cnt    = r_res_cnt;
    assign rd_data    = r_buf[rd_addr];

endmodule
